fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register and PC+4 adder with three pieces:
- a PC register holding the address of the next fetch;
- a one-outstanding-request instruction-memory port with a request/response handshake, so the memory may stall;
- a small instruction queue feeding decode under valid/ready.

Redirects from execute (branch taken, j, jal, jr) flush the queue and discard any in-flight response. Decode receives each instruction together with its PC and PC+4, which is the link value for jal.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential increment.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_WIDTH  fetch address.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  DATA_WIDTH  response instruction.
- redirect_valid  in  1  execute requests PC redirect.
- redirect_target  in  ADDR_WIDTH  new fetch address.
- instr_valid  out  1  queue head valid.
- instr  out  DATA_WIDTH  queue head instruction.
- instr_pc  out  ADDR_WIDTH  PC of head.
- instr_pc_next  out  ADDR_WIDTH  head PC + PC_STEP.
- instr_ready  in  1  decode consumes head.

## Operation
FSM states and transitions:
- REQ: imem_req=1, imem_addr=pc.
  - Request is issued only if queue count < QUEUE_DEPTH.
  - On imem_gnt: pc <= pc+PC_STEP, go to WAIT.
- WAIT: imem_req=0.
  - On imem_rvalid: push {pc_of_req, imem_rdata} into the queue, go to REQ.
- DROP: imem_req=0.
  - On imem_rvalid: discard the data, go to REQ.
- pc_of_req is captured at grant.
- The issue gate guarantees the queue is never full when a response returns.

Redirect (redirect_valid=1) has priority over everything else:
- Flush the queue (count <= 0).
- pc <= redirect_target.
- Next state:
  - REQ if no request is outstanding after this cycle;
  - DROP if in WAIT without rvalid this cycle;
  - DROP if in REQ with imem_gnt this cycle, since that grant is stale and pc is not incremented.
  - If in WAIT or DROP with rvalid in the same cycle, the response is discarded and the next state is REQ.
- Redirect while already in DROP: stay in DROP and latch the new target.

Other rules:
- Queue pop happens when instr_valid && instr_ready && !redirect_valid. During a redirect cycle, decode squashes the head itself.
- Push and pop may occur in the same cycle; count is unchanged.
- PC arithmetic is modulo 2^ADDR_WIDTH: wrap from all-ones-minus-3 to 0 is silent.
- instr_pc_next is computed at push and stored in the entry.

## Timing
Reset values:
- state=REQ, pc=RESET_PC, queue empty.
- imem_req=0 while reset=1; instr_valid=0.
- All data outputs are 0 while empty.

Latency and throughput:
- First imem_req is asserted in the first cycle after reset deasserts, with imem_addr=RESET_PC.
- imem_rvalid is earliest one cycle after grant. A same-cycle response is illegal and is an assertion error.
- A pushed entry is visible at instr_valid the cycle after rvalid; the queue outputs are registered.
- Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect → imem_req with imem_addr=target in the next cycle when nothing is outstanding.
- imem_req/imem_addr stay stable while imem_req=1 && !imem_gnt, unless a redirect occurs.
- Reset mid-operation discards the outstanding request. The memory must ignore a response returning after reset; the fetch unit drops any rvalid seen in REQ.

## Structure
cpu_pkg holds:
- fetch_state_t (REQ, WAIT, DROP);
- FETCH_RESET_PC and FETCH_PC_STEP defaults.

Sub-module fetch_queue:
- synchronous FIFO of {pc, pc_next, instr};
- push, pop, flush and count ports;
- pointers of log2(QUEUE_DEPTH) bits plus a wrap bit.

fetch_unit contains the FSM, PC register and issue gate.

## Test plan
- Reset then memory with 1-cycle latency returning words at 0,4,8, instr_ready=1 → instr_pc sequence 0,4,8 with instr_pc_next 4,8,12; imem_req pattern 1,0,1,0.
- Hold instr_ready=0 → exactly QUEUE_DEPTH=4 entries fill, imem_req stays 0 while full, and no entry is lost after ready returns.
- Redirect to 0x100 while in WAIT (latency 3) → stale response dropped, next imem_addr=0x100, first instr_pc=0x100, queue empty in the cycle after redirect.
- Redirect in the same cycle as imem_gnt at addr 0x20 → state DROP, stale response discarded, next request at the target.
- Redirect coinciding with rvalid and instr_ready → no push, no pop, count=0, next imem_addr=target.
- RESET_PC=0xFFFFFFF8 → fetches at 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap); mid-stream reset returns imem_addr to RESET_PC with instr_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the MIPS core front end.
//   fetch_state_t  - fetch FSM states (REQ, WAIT, DROP)
//   FETCH_RESET_PC - default PC loaded on reset
//   FETCH_PC_STEP  - default sequential PC increment
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // ready to issue a fetch at pc
    WAIT = 2'd1,  // one live request outstanding
    DROP = 2'd2   // one stale request outstanding; its response is discarded
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, pc_next, instr} entries feeding decode.
//   clk, reset          - clock, synchronous active-high reset
//   push, push_*        - write one entry at the tail
//   pop                 - remove the head entry (caller guarantees non-empty)
//   flush               - empty the queue; wins over push and pop
//   count               - number of valid entries (0..QUEUE_DEPTH)
//   head_valid, head_*  - head entry; data fields read as 0 while empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [ADDR_WIDTH-1:0]        push_pc,
  input  logic [ADDR_WIDTH-1:0]        push_pc_next,
  input  logic [DATA_WIDTH-1:0]        push_instr,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                         head_valid,
  output logic [ADDR_WIDTH-1:0]        head_pc,
  output logic [ADDR_WIDTH-1:0]        head_pc_next,
  output logic [DATA_WIDTH-1:0]        head_instr
);

  localparam int          PW      = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         rd_idx;
  logic [ADDR_WIDTH-1:0] pc_mem      [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_next_mem [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem   [QUEUE_DEPTH];

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q[PW-1:0]]      <= push_pc;
      pc_next_mem[wr_ptr_q[PW-1:0]] <= push_pc_next;
      instr_mem[wr_ptr_q[PW-1:0]]   <= push_instr;
    end
  end

  assign rd_idx       = rd_ptr_q[PW-1:0];
  assign count        = wr_ptr_q - rd_ptr_q;
  assign head_valid   = (wr_ptr_q != rd_ptr_q);
  assign head_pc      = head_valid ? pc_mem[rd_idx]      : '0;
  assign head_pc_next = head_valid ? pc_next_mem[rd_idx] : '0;
  assign head_instr   = head_valid ? instr_mem[rd_idx]   : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end (PC register, one-outstanding
// instruction-memory port, instruction queue towards decode).
//   clk, reset                    - clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt   - request handshake; address held until grant
//   imem_rvalid/imem_rdata        - response, at least one cycle after grant
//   redirect_valid/target         - execute redirect; flushes queue, drops
//                                   any in-flight response
//   instr_valid/instr/instr_pc/instr_pc_next/instr_ready
//                                 - queue head towards decode (valid/ready)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(FETCH_RESET_PC),
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(FETCH_PC_STEP)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_next,
  input  logic                  instr_ready
);

  localparam int          PW        = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(QUEUE_DEPTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PW:0]           q_count;
  logic                  q_push, q_pop, q_flush;
  logic                  granted;

  // Only one request is ever outstanding, so issuing while count < depth means
  // the queue always has room when the response arrives.
  assign imem_req  = !reset && (state_q == REQ) && (q_count != DEPTH_CNT);
  assign imem_addr = pc_q;
  assign granted   = imem_req && imem_gnt;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    q_push   = 1'b0;
    q_flush  = redirect_valid;
    q_pop    = instr_valid && instr_ready && !redirect_valid;

    if (redirect_valid) begin
      pc_d = redirect_target;
      unique case (state_q)
        // A grant in the redirect cycle is stale: pc is not advanced and the
        // response must be thrown away.
        REQ:        state_d = granted ? DROP : REQ;
        WAIT, DROP: state_d = imem_rvalid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (granted) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            q_push  = 1'b1;
            state_d = REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_pc     (req_pc_q),
    .push_pc_next(req_pc_q + PC_STEP),
    .push_instr  (imem_rdata),
    .pop         (q_pop),
    .flush       (q_flush),
    .count       (q_count),
    .head_valid  (instr_valid),
    .head_pc     (instr_pc),
    .head_pc_next(instr_pc_next),
    .head_instr  (instr)
  );

  // A response in the same cycle as its grant breaks the memory protocol.
  a_rsp_after_grant: assert property (@(posedge clk) disable iff (reset)
    !(granted && imem_rvalid));

endmodule
